// File: rtl/mem_rr_arbiter_if.sv
// Handshake bundle for mem_rr_arbiter: CNT master request/response ports
// plus the single in-order memory slave port.
// slave modport  : the arbiter's view of the bundle.
// master modport : the surrounding system (masters and memory) driving the arbiter.
interface mem_rr_arbiter_if #(
    parameter int CNT        = 4,
    parameter int REQ_WIDTH  = 64,
    parameter int RESP_WIDTH = 32
);
    // Master side
    logic [CNT-1:0]           m_req_valid;
    logic [CNT-1:0]           m_req_ready;
    logic [CNT*REQ_WIDTH-1:0] m_req_data;
    logic [CNT-1:0]           m_req_lock;
    logic [CNT-1:0]           m_resp_valid;
    logic [CNT-1:0]           m_resp_ready;
    logic [RESP_WIDTH-1:0]    m_resp_data;

    // Memory slave side
    logic                     s_req_valid;
    logic                     s_req_ready;
    logic [REQ_WIDTH-1:0]     s_req_data;
    logic                     s_resp_valid;
    logic                     s_resp_ready;
    logic [RESP_WIDTH-1:0]    s_resp_data;

    modport slave (
        input  m_req_valid, m_req_data, m_req_lock, m_resp_ready,
        input  s_req_ready, s_resp_valid, s_resp_data,
        output m_req_ready, m_resp_valid, m_resp_data,
        output s_req_valid, s_req_data, s_resp_ready
    );

    modport master (
        output m_req_valid, m_req_data, m_req_lock, m_resp_ready,
        output s_req_ready, s_resp_valid, s_resp_data,
        input  m_req_ready, m_resp_valid, m_resp_data,
        input  s_req_valid, s_req_data, s_resp_ready
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin memory arbiter with burst locking.
// CNT masters share one in-order memory slave port. Grants rotate from the
// master after the last one served; a master may keep the grant across beats
// by asserting lock. The index of every accepted request is queued so that
// responses are routed back to their owner in order.
// Optional: define MEM_RR_ARB_PERF_EN to add saturating per-master grant
// counters (perf_grants) and a FIFO-full stall counter (perf_stall).
module mem_rr_arbiter #(
    parameter int CNT         = 4,
    parameter int QUEUE_DEPTH = 4,
    parameter int REQ_WIDTH   = 64,
    parameter int RESP_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_rr_arbiter_if.slave      bus,
    output logic                 busy
`ifdef MEM_RR_ARB_PERF_EN
    ,
    output logic [CNT*16-1:0]    perf_grants,
    output logic [15:0]          perf_stall
`endif
);

    localparam int SEL_W = $clog2(CNT);
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_rr_ptr;
    logic [SEL_W-1:0] w_rr_ptr_nxt;
    logic [SEL_W-1:0] r_owner;
    logic [SEL_W-1:0] w_owner_nxt;
    logic [SEL_W-1:0] w_sel;
    logic [SEL_W-1:0] w_cand;
    logic             w_eligible;

    logic [SEL_W-1:0] r_fifo [QUEUE_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_empty;
    logic [SEL_W-1:0] w_head;

    logic             w_s_req_valid;
    logic             w_push;
    logic             w_pop;

    // Master index `k` steps after `base`, wrapping modulo CNT (CNT need not be a power of two).
    function automatic logic [SEL_W-1:0] rr_index(input logic [SEL_W-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= CNT) sum = sum - CNT;
        return SEL_W'(sum);
    endfunction

    // Pointer advance with wrap at QUEUE_DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign w_full  = (r_count == CNT_W'(QUEUE_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_head  = r_fifo[r_rd_ptr];

    // Select the granted master: the owner while locked, else first valid from rr_ptr.
    // NOTE: every variable written here gets a default first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_sel      = r_owner;
        w_cand     = '0;
        w_eligible = 1'b0;
        if (r_state == ST_LOCKED) begin
            w_eligible = bus.m_req_valid[r_owner];
        end else begin
            for (int k = 0; k < CNT; k++) begin
                w_cand = rr_index(r_rr_ptr, k);
                if (!w_eligible && bus.m_req_valid[w_cand]) begin
                    w_eligible = 1'b1;
                    w_sel      = w_cand;
                end
            end
        end
    end

    // Request valid is held low during reset and never looks at s_req_ready.
    assign w_s_req_valid   = rst && w_eligible && !w_full;
    assign w_push          = w_s_req_valid && bus.s_req_ready;
    assign bus.s_req_valid = w_s_req_valid;
    assign bus.s_req_data  = bus.m_req_data[w_sel*REQ_WIDTH +: REQ_WIDTH];

    // Only the granted master sees its beat accepted.
    always_comb begin
        bus.m_req_ready = '0;
        if (w_push) bus.m_req_ready[w_sel] = 1'b1;
    end

    // Response routing: the FIFO head names the master that owns the next response.
    assign bus.s_resp_ready = !w_empty && bus.m_resp_ready[w_head];
    assign w_pop            = bus.s_resp_valid && bus.s_resp_ready;
    assign bus.m_resp_data  = bus.s_resp_data;
    assign busy             = !w_empty;

    // Steer s_resp_valid to the head master only.
    always_comb begin
        bus.m_resp_valid = '0;
        if (bus.s_resp_valid && !w_empty) bus.m_resp_valid[w_head] = 1'b1;
    end

    // Arbiter next state: rotate past the served master; lock follows the beat's lock bit.
    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_owner_nxt  = r_owner;
        if (w_push) begin
            w_rr_ptr_nxt = (w_sel == SEL_W'(CNT - 1)) ? '0 : w_sel + 1'b1;
            if (bus.m_req_lock[w_sel]) begin
                w_state_nxt = ST_LOCKED;
                w_owner_nxt = w_sel;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    // Arbiter state registers.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_owner  <= w_owner_nxt;
        end
    end

    // Index FIFO control: pointers and occupancy; a full FIFO never pushes, even on a pop cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Index FIFO storage.
    // NOTE: storage is not reset; r_count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_sel;
    end

`ifdef MEM_RR_ARB_PERF_EN
    logic [15:0] r_perf_grants [CNT];
    logic [15:0] r_perf_stall;

    // Saturating accepted-request counter per master.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CNT; i++) r_perf_grants[i] <= '0;
        end else begin
            for (int i = 0; i < CNT; i++) begin
                if (w_push && (w_sel == SEL_W'(i)) && (r_perf_grants[i] != 16'hFFFF))
                    r_perf_grants[i] <= r_perf_grants[i] + 16'd1;
            end
        end
    end

    // Saturating count of cycles where a request was eligible but the FIFO was full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_stall <= '0;
        end else if (w_eligible && w_full && (r_perf_stall != 16'hFFFF)) begin
            r_perf_stall <= r_perf_stall + 16'd1;
        end
    end

    for (genvar g = 0; g < CNT; g++) begin : g_perf
        assign perf_grants[g*16 +: 16] = r_perf_grants[g];
    end
    assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter (CNT=4, QUEUE_DEPTH=4).
// Inputs change 1 time unit after the rising edge; outputs are compared
// 1 unit later, well away from the next edge.
module tb_mem_rr_arbiter;

    localparam int CNT = 4;
    localparam int QD  = 4;
    localparam int RW  = 64;
    localparam int SW  = 32;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    always #5 clk = ~clk;

    mem_rr_arbiter_if #(.CNT(CNT), .REQ_WIDTH(RW), .RESP_WIDTH(SW)) bus ();

`ifdef MEM_RR_ARB_PERF_EN
    logic [CNT*16-1:0] perf_grants;
    logic [15:0]       perf_stall;
`endif

    mem_rr_arbiter #(
        .CNT(CNT), .QUEUE_DEPTH(QD), .REQ_WIDTH(RW), .RESP_WIDTH(SW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
`ifdef MEM_RR_ARB_PERF_EN
        ,
        .perf_grants (perf_grants),
        .perf_stall  (perf_stall)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Expected grant sequences (master indices / one-hot ready vectors).
    int         fair_seq  [12] = '{0, 1, 2, 0, 1, 2, 3, 0, 1, 2, 3, 0};
    logic [3:0] lock_vld  [7]  = '{4'b0011, 4'b0011, 4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0001};
    logic [3:0] lock_lck  [7]  = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    logic [3:0] lock_rdy  [7]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0001};

    initial begin
        // ---------------- Reset with arbitrary inputs ----------------
        rst              = 1'b0;
        bus.m_req_valid  = 4'b1111;
        bus.m_req_lock   = 4'b1010;
        bus.m_resp_ready = 4'b1111;
        bus.s_req_ready  = 1'b1;
        bus.s_resp_valid = 1'b1;
        bus.s_resp_data  = 32'h5A5A_0000;
        for (int i = 0; i < CNT; i++) bus.m_req_data[i*RW +: RW] = 64'h1000 + 64'(i);
        #12;
        check("rst_m_req_ready",  64'(bus.m_req_ready),  64'h0);
        check("rst_s_req_valid",  64'(bus.s_req_valid),  64'h0);
        check("rst_s_resp_ready", 64'(bus.s_resp_ready), 64'h0);
        check("rst_m_resp_valid", 64'(bus.m_resp_valid), 64'h0);
        check("rst_busy",         64'(busy),             64'h0);

        // ---------------- Fairness, immediate responses ----------------
        step();
        rst             = 1'b1;
        bus.m_req_valid = 4'b0111;
        bus.m_req_lock  = 4'b0000;
        for (int i = 0; i < 12; i++) begin
            if (i == 6) bus.m_req_valid = 4'b1111;
            settle();
            check($sformatf("fair_grant%0d", i), 64'(bus.m_req_ready), 64'd1 << fair_seq[i]);
            if (i == 0) begin
                check("first_s_req_data", 64'(bus.s_req_data), 64'h1000);
                check("stray_resp_ready", 64'(bus.s_resp_ready), 64'h0);
                check("stray_resp_valid", 64'(bus.m_resp_valid), 64'h0);
            end else begin
                check($sformatf("fair_route%0d", i), 64'(bus.m_resp_valid), 64'd1 << fair_seq[i-1]);
            end
            step();
        end
        bus.m_req_valid = 4'b0000;
        settle();
        check("fair_last_route", 64'(bus.m_resp_valid), 64'b0001);
        check("resp_broadcast",  64'(bus.m_resp_data),  64'h5A5A_0000);
        step();
        check("fair_drained_busy", 64'(busy), 64'h0);

        // ---------------- Lock burst from master 1 ----------------
        for (int i = 0; i < 7; i++) begin
            bus.m_req_valid = lock_vld[i];
            bus.m_req_lock  = lock_lck[i];
            settle();
            check($sformatf("lock_ready%0d", i), 64'(bus.m_req_ready), 64'(lock_rdy[i]));
            check($sformatf("lock_sreqv%0d", i), 64'(bus.s_req_valid), 64'(lock_rdy[i] != 4'b0000));
            step();
        end
        bus.m_req_valid = 4'b0000;
        bus.m_req_lock  = 4'b0000;
        settle();
        step();
        check("lock_drained_busy", 64'(busy), 64'h0);

        // ---------------- FIFO full boundary ----------------
        bus.s_resp_valid = 1'b0;
        bus.m_req_valid  = 4'b0001;
        for (int i = 0; i < QD; i++) begin
            settle();
            check($sformatf("fill_grant%0d", i), 64'(bus.m_req_ready), 64'b0001);
            step();
        end
        settle();
        check("full_s_req_valid", 64'(bus.s_req_valid), 64'h0);
        check("full_m_req_ready", 64'(bus.m_req_ready), 64'h0);
        check("full_busy",        64'(busy),            64'h1);
        step();
        bus.s_resp_valid = 1'b1;
        settle();
        check("pop_s_resp_ready",  64'(bus.s_resp_ready), 64'h1);
        check("pop_m_resp_valid",  64'(bus.m_resp_valid), 64'b0001);
        check("pop_cycle_no_push", 64'(bus.s_req_valid),  64'h0);
        step();
        bus.s_resp_valid = 1'b0;
        settle();
        check("after_pop_s_req_valid", 64'(bus.s_req_valid), 64'h1);
        check("after_pop_grant",       64'(bus.m_req_ready), 64'b0001);
        step();
        bus.m_req_valid  = 4'b0000;
        bus.s_resp_valid = 1'b1;
        for (int i = 0; i < QD; i++) step();
        check("full_drained_busy", 64'(busy), 64'h0);

        // ---------------- Routing and response backpressure ----------------
        bus.s_resp_valid = 1'b0;
        bus.m_req_valid  = 4'b0100;
        settle();
        check("route_grant2", 64'(bus.m_req_ready), 64'b0100);
        check("route_data2",  64'(bus.s_req_data),  64'h1002);
        step();
        bus.m_req_valid = 4'b0001;
        settle();
        check("route_grant0", 64'(bus.m_req_ready), 64'b0001);
        step();
        bus.m_req_valid  = 4'b0000;
        bus.s_resp_valid = 1'b1;
        bus.s_resp_data  = 32'h0000_000A;
        bus.m_resp_ready = 4'b1011;
        settle();
        check("route_a_valid",    64'(bus.m_resp_valid), 64'b0100);
        check("route_a_data",     64'(bus.m_resp_data),  64'hA);
        check("route_a_backpres", 64'(bus.s_resp_ready), 64'h0);
        step();
        check("route_no_reorder", 64'(bus.m_resp_valid), 64'b0100);
        bus.m_resp_ready = 4'b1111;
        settle();
        check("route_a_ready", 64'(bus.s_resp_ready), 64'h1);
        step();
        bus.s_resp_data = 32'h0000_000B;
        settle();
        check("route_b_valid", 64'(bus.m_resp_valid), 64'b0001);
        check("route_b_data",  64'(bus.m_resp_data),  64'hB);
        check("route_b_ready", 64'(bus.s_resp_ready), 64'h1);
        step();
        bus.s_resp_valid = 1'b0;
        settle();
        check("route_drained_busy", 64'(busy), 64'h0);

        // ---------------- Async reset while locked with 3 outstanding ----------------
        bus.m_req_valid = 4'b0010;
        bus.m_req_lock  = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("pre_rst_grant%0d", i), 64'(bus.m_req_ready), 64'b0010);
            step();
        end
        bus.m_req_valid  = 4'b0011;
        bus.m_req_lock   = 4'b0000;
        bus.s_resp_valid = 1'b1;
        settle();
        check("pre_rst_locked", 64'(bus.m_req_ready), 64'b0010);
        check("pre_rst_busy",   64'(busy),            64'h1);
        rst = 1'b0;
        settle();
        check("mid_rst_m_req_ready",  64'(bus.m_req_ready),  64'h0);
        check("mid_rst_s_req_valid",  64'(bus.s_req_valid),  64'h0);
        check("mid_rst_s_resp_ready", 64'(bus.s_resp_ready), 64'h0);
        check("mid_rst_m_resp_valid", 64'(bus.m_resp_valid), 64'h0);
        check("mid_rst_busy",         64'(busy),             64'h0);
        rst = 1'b1;
        settle();
        check("post_rst_busy",  64'(busy),            64'h0);
        check("post_rst_grant", 64'(bus.m_req_ready), 64'b0001);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Round-robin memory arbiter with burst locking; shares one in-order memory slave port among CNT masters.
- Used where fairness matters (e.g. multiple cores or DMA engines sharing the L2/memory bus), unlike fixed-priority arbitration.
- A master can hold the grant across consecutive request beats (cache-line refill or write burst) by asserting lock.
- Responses are routed back in order through an internal FIFO of master indices.

Parameters:
CNT, 4, number of master ports (>=2; need not be a power of two)
QUEUE_DEPTH, 4, maximum outstanding requests (index FIFO depth, >=1)
REQ_WIDTH, 64, request payload width
RESP_WIDTH, 32, response payload width

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
m_req_valid  input  CNT  per-master request valid
m_req_ready  output  CNT  per-master request accepted
m_req_data  input  CNT*REQ_WIDTH  per-master payload; master i occupies bits [i*REQ_WIDTH +: REQ_WIDTH]
m_req_lock  input  CNT  per-master: keep grant after this beat
m_resp_valid  output  CNT  per-master response valid
m_resp_ready  input  CNT  per-master response ready
m_resp_data  output  RESP_WIDTH  response payload, broadcast to all masters
s_req_valid  output  1  slave request valid
s_req_ready  input  1  slave request ready
s_req_data  output  REQ_WIDTH  payload of the granted master
s_resp_valid  input  1  slave response valid
s_resp_ready  output  1  slave response ready
busy  output  1  one or more requests outstanding

Behaviour:
- Clocking and reset
  - Clock is clk; reset is rst, asynchronous, active-low.
  - While rst is low: state=IDLE, rr_ptr=0, owner=0, FIFO empty.
  - All outputs during reset are 0: m_req_ready, m_resp_valid, s_req_valid, s_resp_ready, busy.
  - Data outputs are don't-care during reset.
- Fire rule: a transfer fires when valid && ready.
  - s_req_valid must not depend combinationally on s_req_ready.
- Arbiter states: IDLE, LOCKED.
  - IDLE: sel = first i with m_req_valid[i], scanning rr_ptr, rr_ptr+1, ... modulo CNT.
  - LOCKED: only owner is eligible; sel=owner; all other m_req_ready stay 0.
- Request path (combinational, zero latency)
  - s_req_valid = eligible request present && FIFO not full.
  - s_req_data = slice sel of m_req_data.
  - m_req_ready[i] = s_req fire && sel==i.
- On s_req fire:
  - Push sel into the FIFO.
  - rr_ptr <= sel+1, wrapping to 0 when sel+1==CNT.
  - If m_req_lock[sel]: state<=LOCKED, owner<=sel. Otherwise state<=IDLE.
- LOCKED corner cases
  - If owner drops valid, remain LOCKED and wait.
  - Lock is released only by an owner beat with lock=0.
- Grant stability: rr_ptr changes only on fire, so sel is stable while masters hold valid.
- Response path
  - head = FIFO head index.
  - m_resp_valid[i] = s_resp_valid && FIFO non-empty && head==i.
  - s_resp_ready = FIFO non-empty && m_resp_ready[head].
  - On s_resp fire: pop.
  - Empty FIFO: s_resp_ready=0; stray slave responses stall and are never dropped.
- FIFO boundaries
  - Full: no push, even if a pop occurs in the same cycle, so the slot frees the following cycle.
  - Simultaneous push and pop when not full: count unchanged, both take effect.
- busy = FIFO non-empty.
- Reset mid-operation: outstanding index entries and lock are discarded; the slave must be reset together with the arbiter.

Optional Feature:
- Macro: MEM_RR_ARB_PERF_EN.
- Defined:
  - Adds output perf_grants, CNT*16 bits: per-master 16-bit counters of accepted requests.
  - Adds output perf_stall, 16 bits: cycles with an eligible request but the FIFO full.
  - All counters saturate at 16'hFFFF and reset to 0.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst low with arbitrary inputs -> every control output 0 and busy=0; release -> rr_ptr=0, first valid master 0 is granted.
- Fairness: CNT=4, masters 0,1,2 valid continuously with lock=0, s_req_ready=1, responses returned immediately -> grant order 0,1,2,0,1,2; master 3 joins -> order becomes 0,1,2,3.
- Lock burst: master 1 sends 4 beats with lock=1,1,1,0, master 0 valid throughout, master 1 drops valid for 2 cycles mid-burst -> four consecutive grants to 1 with no grant to 0, then 0 granted.
- FIFO full: QUEUE_DEPTH=4, s_resp_valid=0, 4 requests accepted -> s_req_valid=0 with a 5th pending; one response popped -> 5th accepted the following cycle, never in the pop cycle.
- Routing/backpressure: requests from 2 then 0; responses 32'hA, then 32'hB -> m_resp_valid[2] carries A, then m_resp_valid[0] carries B; holding m_resp_ready[2]=0 -> s_resp_ready=0, and B is not delivered first.
- Async reset mid-lock: rst low while LOCKED with 3 outstanding -> outputs 0 immediately; after release: state IDLE, busy=0, master 0 granted.
